// File: rtl/rf_rename_nport.sv
// rf_rename_nport: multi-port architectural register file with a per-register
// scoreboard (valid bit + latest producer tag), sitting between dispatch/ROB
// and RF storage.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           mark every register valid; drops same-cycle renames
//   rn_en/dest/tag  per-slot destination rename (producer ROB tag)
//   rd_req/src1/2   per-slot two-source read request
//   rd1_*/rd2_*     registered read responses (ready, valid_bit, data, tag)
//   wb_en/target/   per-port commit write; valid is restored only when the
//   data/tag        committing tag matches the latest renamer
module rf_rename_nport #(
  parameter int unsigned OPRAND_WIDTH  = 32,
  parameter int unsigned REGNAME_WIDTH = 5,
  parameter int unsigned ISSUE_WIDTH   = 2,
  parameter int unsigned WB_WIDTH      = 2,
  parameter int unsigned TAG_WIDTH     = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [ISSUE_WIDTH-1:0]                rn_en,
  input  logic [ISSUE_WIDTH*REGNAME_WIDTH-1:0]  rn_dest,
  input  logic [ISSUE_WIDTH*TAG_WIDTH-1:0]      rn_tag,
  input  logic [ISSUE_WIDTH-1:0]                rd_req,
  input  logic [ISSUE_WIDTH*REGNAME_WIDTH-1:0]  rd_src1,
  input  logic [ISSUE_WIDTH*REGNAME_WIDTH-1:0]  rd_src2,
  output logic [ISSUE_WIDTH-1:0]                rd1_ready,
  output logic [ISSUE_WIDTH-1:0]                rd2_ready,
  output logic [ISSUE_WIDTH-1:0]                rd1_valid_bit,
  output logic [ISSUE_WIDTH-1:0]                rd2_valid_bit,
  output logic [ISSUE_WIDTH*OPRAND_WIDTH-1:0]   rd1_data,
  output logic [ISSUE_WIDTH*OPRAND_WIDTH-1:0]   rd2_data,
  output logic [ISSUE_WIDTH*TAG_WIDTH-1:0]      rd1_tag,
  output logic [ISSUE_WIDTH*TAG_WIDTH-1:0]      rd2_tag,
  input  logic [WB_WIDTH-1:0]                   wb_en,
  input  logic [WB_WIDTH*REGNAME_WIDTH-1:0]     wb_target,
  input  logic [WB_WIDTH*OPRAND_WIDTH-1:0]      wb_data,
  input  logic [WB_WIDTH*TAG_WIDTH-1:0]         wb_tag
);

  localparam int unsigned NumRegs = 2 ** REGNAME_WIDTH;

  logic [OPRAND_WIDTH-1:0] data_q [NumRegs];
  logic [OPRAND_WIDTH-1:0] data_d [NumRegs];
  logic [TAG_WIDTH-1:0]    tag_q  [NumRegs];
  logic [TAG_WIDTH-1:0]    tag_d  [NumRegs];
  logic [NumRegs-1:0]      valid_q, valid_d;

  // Per-register commit resolution: the highest-index port hitting a
  // register supplies both the data and the tag check.
  logic [NumRegs-1:0]      cm_hit, cm_set;
  logic [OPRAND_WIDTH-1:0] cm_data [NumRegs];

  always_comb begin
    logic [REGNAME_WIDTH-1:0] tgt;
    tgt    = '0;
    cm_hit = '0;
    cm_set = '0;
    for (int r = 0; r < NumRegs; r++) cm_data[r] = '0;
    for (int k = 0; k < WB_WIDTH; k++) begin
      if (wb_en[k]) begin
        tgt          = wb_target[k*REGNAME_WIDTH +: REGNAME_WIDTH];
        cm_hit[tgt]  = 1'b1;
        cm_data[tgt] = wb_data[k*OPRAND_WIDTH +: OPRAND_WIDTH];
        cm_set[tgt]  = !valid_q[tgt] && (tag_q[tgt] == wb_tag[k*TAG_WIDTH +: TAG_WIDTH]);
      end
    end
    cm_hit[0]  = 1'b0;
    cm_set[0]  = 1'b0;
    cm_data[0] = '0;
  end

  // Next architectural state: commit first, then rename overrides valid/tag.
  always_comb begin
    logic [REGNAME_WIDTH-1:0] dst;
    dst = '0;
    for (int r = 0; r < NumRegs; r++) begin
      data_d[r] = cm_hit[r] ? cm_data[r] : data_q[r];
      tag_d[r]  = tag_q[r];
    end
    valid_d = valid_q | cm_set;
    if (flush) begin
      valid_d = '1;
    end else begin
      // Ascending order so the highest slot wins on a shared destination.
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (rn_en[i]) begin
          dst          = rn_dest[i*REGNAME_WIDTH +: REGNAME_WIDTH];
          valid_d[dst] = 1'b0;
          tag_d[dst]   = rn_tag[i*TAG_WIDTH +: TAG_WIDTH];
        end
      end
    end
    valid_d[0] = 1'b1;
    tag_d[0]   = '0;
    data_d[0]  = '0;
  end

  // Read response computation for every slot and both sources.
  logic [ISSUE_WIDTH-1:0]              vb1_d, vb2_d;
  logic [ISSUE_WIDTH*OPRAND_WIDTH-1:0] dat1_d, dat2_d;
  logic [ISSUE_WIDTH*TAG_WIDTH-1:0]    tg1_d, tg2_d;

  always_comb begin
    logic [REGNAME_WIDTH-1:0] src;
    logic                     fwd_hit;
    logic [TAG_WIDTH-1:0]     fwd_tag;
    logic                     vb;
    logic [OPRAND_WIDTH-1:0]  dat;
    logic [TAG_WIDTH-1:0]     tg;
    src     = '0;
    fwd_hit = 1'b0;
    fwd_tag = '0;
    vb      = 1'b0;
    dat     = '0;
    tg      = '0;
    vb1_d   = '0;
    vb2_d   = '0;
    dat1_d  = '0;
    dat2_d  = '0;
    tg1_d   = '0;
    tg2_d   = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      for (int s = 0; s < 2; s++) begin
        src = (s == 0) ? rd_src1[i*REGNAME_WIDTH +: REGNAME_WIDTH]
                       : rd_src2[i*REGNAME_WIDTH +: REGNAME_WIDTH];
        // Nearest older slot in the bundle renaming this source wins.
        fwd_hit = 1'b0;
        fwd_tag = '0;
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
          if (j < i && rn_en[j] &&
              rn_dest[j*REGNAME_WIDTH +: REGNAME_WIDTH] == src) begin
            fwd_hit = 1'b1;
            fwd_tag = rn_tag[j*TAG_WIDTH +: TAG_WIDTH];
          end
        end
        vb  = 1'b0;
        dat = '0;
        tg  = '0;
        if (!rd_req[i]) begin
          vb = 1'b0;
        end else if (src == '0) begin
          vb = 1'b1;
        end else if (fwd_hit) begin
          tg = fwd_tag;
        end else if (cm_set[src]) begin
          vb  = 1'b1;
          dat = cm_data[src];
        end else if (flush) begin
          vb  = 1'b1;
          dat = data_d[src];
        end else if (valid_q[src]) begin
          vb  = 1'b1;
          dat = data_q[src];
        end else begin
          tg = tag_q[src];
        end
        if (s == 0) begin
          vb1_d[i]                           = vb;
          dat1_d[i*OPRAND_WIDTH +: OPRAND_WIDTH] = dat;
          tg1_d[i*TAG_WIDTH +: TAG_WIDTH]    = tg;
        end else begin
          vb2_d[i]                           = vb;
          dat2_d[i*OPRAND_WIDTH +: OPRAND_WIDTH] = dat;
          tg2_d[i*TAG_WIDTH +: TAG_WIDTH]    = tg;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NumRegs; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      valid_q       <= '1;
      rd1_ready     <= '0;
      rd2_ready     <= '0;
      rd1_valid_bit <= '0;
      rd2_valid_bit <= '0;
      rd1_data      <= '0;
      rd2_data      <= '0;
      rd1_tag       <= '0;
      rd2_tag       <= '0;
    end else begin
      for (int r = 0; r < NumRegs; r++) begin
        data_q[r] <= data_d[r];
        tag_q[r]  <= tag_d[r];
      end
      valid_q       <= valid_d;
      rd1_ready     <= rd_req;
      rd2_ready     <= rd_req;
      rd1_valid_bit <= vb1_d;
      rd2_valid_bit <= vb2_d;
      rd1_data      <= dat1_d;
      rd2_data      <= dat2_d;
      rd1_tag       <= tg1_d;
      rd2_tag       <= tg2_d;
    end
  end

endmodule

// File: tb/tb_rf_rename_nport.sv
// Directed bench for rf_rename_nport with default parameters
// (32-bit data, 32 registers, 2 issue slots, 2 commit ports, 4-bit tags).
module tb_rf_rename_nport;

  localparam int unsigned OW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned IW = 2;
  localparam int unsigned WW = 2;
  localparam int unsigned TW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [IW-1:0]    rn_en;
  logic [IW*RW-1:0] rn_dest;
  logic [IW*TW-1:0] rn_tag;
  logic [IW-1:0]    rd_req;
  logic [IW*RW-1:0] rd_src1, rd_src2;
  logic [IW-1:0]    rd1_ready, rd2_ready, rd1_valid_bit, rd2_valid_bit;
  logic [IW*OW-1:0] rd1_data, rd2_data;
  logic [IW*TW-1:0] rd1_tag, rd2_tag;
  logic [WW-1:0]    wb_en;
  logic [WW*RW-1:0] wb_target;
  logic [WW*OW-1:0] wb_data;
  logic [WW*TW-1:0] wb_tag;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_rename_nport #(
    .OPRAND_WIDTH (OW),
    .REGNAME_WIDTH(RW),
    .ISSUE_WIDTH  (IW),
    .WB_WIDTH     (WW),
    .TAG_WIDTH    (TW)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .rn_en        (rn_en),
    .rn_dest      (rn_dest),
    .rn_tag       (rn_tag),
    .rd_req       (rd_req),
    .rd_src1      (rd_src1),
    .rd_src2      (rd_src2),
    .rd1_ready    (rd1_ready),
    .rd2_ready    (rd2_ready),
    .rd1_valid_bit(rd1_valid_bit),
    .rd2_valid_bit(rd2_valid_bit),
    .rd1_data     (rd1_data),
    .rd2_data     (rd2_data),
    .rd1_tag      (rd1_tag),
    .rd2_tag      (rd2_tag),
    .wb_en        (wb_en),
    .wb_target    (wb_target),
    .wb_data      (wb_data),
    .wb_tag       (wb_tag)
  );

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic clr();
    flush     = 1'b0;
    rn_en     = '0;
    rn_dest   = '0;
    rn_tag    = '0;
    rd_req    = '0;
    rd_src1   = '0;
    rd_src2   = '0;
    wb_en     = '0;
    wb_target = '0;
    wb_data   = '0;
    wb_tag    = '0;
  endtask

  task automatic rn(input int s, input logic [RW-1:0] d, input logic [TW-1:0] t);
    rn_en[s]          = 1'b1;
    rn_dest[s*RW +: RW] = d;
    rn_tag[s*TW +: TW]  = t;
  endtask

  task automatic rd(input int s, input logic [RW-1:0] a, input logic [RW-1:0] b);
    rd_req[s]           = 1'b1;
    rd_src1[s*RW +: RW] = a;
    rd_src2[s*RW +: RW] = b;
  endtask

  task automatic wb(input int p, input logic [RW-1:0] r, input logic [OW-1:0] d,
                    input logic [TW-1:0] t);
    wb_en[p]              = 1'b1;
    wb_target[p*RW +: RW] = r;
    wb_data[p*OW +: OW]   = d;
    wb_tag[p*TW +: TW]    = t;
  endtask

  // Apply the driven inputs at one edge, then sample #1 later and clear.
  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    clr();
    rst = 1'b1;
    rd(0, 5'd5, 5'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    clr();
    check_eq("rst_ready", {62'd0, rd1_ready}, 64'd0);
    check_eq("rst_data", {32'd0, rd1_data[31:0]}, 64'd0);
    check_eq("rst_vb", {62'd0, rd1_valid_bit}, 64'd0);
    rst = 1'b0;

    // First read after reset.
    rd(0, 5'd5, 5'd0);
    step();
    check_eq("rd0_ready1", {62'd0, rd1_ready}, 64'd1);
    check_eq("rd0_ready2", {62'd0, rd2_ready}, 64'd1);
    check_eq("rd0_vb1", {63'd0, rd1_valid_bit[0]}, 64'd1);
    check_eq("rd0_data1", {32'd0, rd1_data[31:0]}, 64'd0);
    check_eq("rd0_data2", {32'd0, rd2_data[31:0]}, 64'd0);

    // Rename r3 then read it.
    rn(0, 5'd3, 4'd7);
    step();
    check_eq("idle_ready", {62'd0, rd1_ready}, 64'd0);
    rd(0, 5'd3, 5'd0);
    step();
    check_eq("r3_pend_vb", {63'd0, rd1_valid_bit[0]}, 64'd0);
    check_eq("r3_pend_tag", {60'd0, rd1_tag[3:0]}, 64'd7);
    check_eq("r3_pend_data", {32'd0, rd1_data[31:0]}, 64'd0);

    // Commit with same-cycle read takes the bypass.
    wb(0, 5'd3, 32'hDEADBEEF, 4'd7);
    rd(0, 5'd3, 5'd0);
    step();
    check_eq("r3_byp_vb", {63'd0, rd1_valid_bit[0]}, 64'd1);
    check_eq("r3_byp_data", {32'd0, rd1_data[31:0]}, 64'hDEADBEEF);
    check_eq("r3_byp_tag", {60'd0, rd1_tag[3:0]}, 64'd0);
    rd(1, 5'd0, 5'd3);
    step();
    check_eq("r3_stored", {32'd0, rd2_data[63:32]}, 64'hDEADBEEF);

    // WAW: stale commit must not restore valid.
    rn(0, 5'd4, 4'd2);
    step();
    rn(0, 5'd4, 4'd5);
    step();
    wb(0, 5'd4, 32'h11, 4'd2);
    rd(0, 5'd4, 5'd0);
    step();
    check_eq("waw_same_vb", {63'd0, rd1_valid_bit[0]}, 64'd0);
    check_eq("waw_same_tag", {60'd0, rd1_tag[3:0]}, 64'd5);
    rd(0, 5'd4, 5'd0);
    step();
    check_eq("waw_vb", {63'd0, rd1_valid_bit[0]}, 64'd0);
    check_eq("waw_tag", {60'd0, rd1_tag[3:0]}, 64'd5);
    wb(1, 5'd4, 32'h22, 4'd5);
    step();
    rd(0, 5'd4, 5'd0);
    step();
    check_eq("waw2_vb", {63'd0, rd1_valid_bit[0]}, 64'd1);
    check_eq("waw2_data", {32'd0, rd1_data[31:0]}, 64'h22);

    // Commit to a valid register writes data without a tag match.
    wb(0, 5'd6, 32'h66, 4'd0);
    step();
    // Intra-bundle: slot1 sees slot0's rename, slot0 sees prior state.
    rn(0, 5'd6, 4'd9);
    rd(0, 5'd6, 5'd0);
    rd(1, 5'd6, 5'd0);
    step();
    check_eq("intra_s1_vb", {63'd0, rd1_valid_bit[1]}, 64'd0);
    check_eq("intra_s1_tag", {60'd0, rd1_tag[7:4]}, 64'd9);
    check_eq("intra_s0_vb", {63'd0, rd1_valid_bit[0]}, 64'd1);
    check_eq("intra_s0_data", {32'd0, rd1_data[31:0]}, 64'h66);

    // Same destination in two slots: higher slot's tag wins.
    rn(0, 5'd7, 4'd1);
    rn(1, 5'd7, 4'd2);
    step();
    rd(0, 5'd0, 5'd7);
    step();
    check_eq("dup_rn_tag", {60'd0, rd2_tag[3:0]}, 64'd2);

    // Flush.
    wb(0, 5'd8, 32'h88, 4'd0);
    wb(1, 5'd9, 32'h99, 4'd0);
    step();
    wb(0, 5'd10, 32'hAA, 4'd0);
    step();
    rn(0, 5'd8, 4'd3);
    rn(1, 5'd9, 4'd4);
    step();
    flush = 1'b1;
    rn(0, 5'd10, 4'd6);
    step();
    rd(0, 5'd8, 5'd9);
    rd(1, 5'd10, 5'd6);
    step();
    check_eq("fl_r8_vb", {63'd0, rd1_valid_bit[0]}, 64'd1);
    check_eq("fl_r8_data", {32'd0, rd1_data[31:0]}, 64'h88);
    check_eq("fl_r9_data", {32'd0, rd2_data[31:0]}, 64'h99);
    check_eq("fl_r10_vb", {63'd0, rd1_valid_bit[1]}, 64'd1);
    check_eq("fl_r10_data", {32'd0, rd1_data[63:32]}, 64'hAA);
    check_eq("fl_r6_data", {32'd0, rd2_data[63:32]}, 64'h66);
    check_eq("fl_r8_tag", {60'd0, rd1_tag[3:0]}, 64'd0);

    // Register 0 ignores commits and renames.
    wb(0, 5'd0, 32'h55, 4'd0);
    rn(0, 5'd0, 4'd3);
    step();
    rd(0, 5'd0, 5'd0);
    step();
    check_eq("r0_vb", {63'd0, rd1_valid_bit[0]}, 64'd1);
    check_eq("r0_data", {32'd0, rd1_data[31:0]}, 64'd0);
    check_eq("r0_tag", {60'd0, rd2_tag[3:0]}, 64'd0);

    // Two commit ports on the same target: port1 wins.
    wb(0, 5'd12, 32'hA, 4'd0);
    wb(1, 5'd12, 32'hB, 4'd0);
    step();
    rd(1, 5'd12, 5'd0);
    step();
    check_eq("wb_conf_data", {32'd0, rd1_data[63:32]}, 64'hB);

    // Rename and commit on one register: rename wins, data is still written.
    rn(0, 5'd13, 4'd1);
    wb(0, 5'd13, 32'h13, 4'd0);
    step();
    rd(0, 5'd13, 5'd0);
    step();
    check_eq("rncm_vb", {63'd0, rd1_valid_bit[0]}, 64'd0);
    check_eq("rncm_tag", {60'd0, rd1_tag[3:0]}, 64'd1);
    flush = 1'b1;
    rd(0, 5'd13, 5'd0);
    step();
    check_eq("rncm_fl_data", {32'd0, rd1_data[31:0]}, 64'h13);
    check_eq("rncm_fl_vb", {63'd0, rd1_valid_bit[0]}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
